// File: rtl/smi_mem_write_burst_arbiter_2x_pkg.sv
// Shared types and default widths for the two-port write burst arbiter.
package smi_mem_arb_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned ADDR_W_DEF = 64;
    localparam int unsigned LEN_W_DEF  = 32;
    localparam int unsigned OPTS_W     = 8;

    typedef enum logic [1:0] {
        Idle   = 2'd0,
        Params = 2'd1,
        Data   = 2'd2,
        Done   = 2'd3
    } arbState_t;

endpackage

// File: rtl/smi_mem_write_burst_arbiter_2x_if.sv
// Write burst channel set (params, data, done) with valid/stop handshakes.
// master = side that issues bursts, slave = side that executes them.
interface smi_mem_write_burst_arbiter_2x_if
    import smi_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
);
    logic              paramsValid;
    logic [ADDR_W-1:0] paramBurstAddr;
    logic [LEN_W-1:0]  paramBurstLen;
    logic [OPTS_W-1:0] paramBurstOpts;
    logic              paramsStop;
    logic              dataValid;
    logic [DATA_W-1:0] dataValue;
    logic              dataStop;
    logic              doneValid;
    logic              doneStatusOk;
    logic              doneStop;

    modport master (
        output paramsValid, paramBurstAddr, paramBurstLen, paramBurstOpts,
        output dataValid, dataValue, doneStop,
        input  paramsStop, dataStop, doneValid, doneStatusOk
    );

    modport slave (
        input  paramsValid, paramBurstAddr, paramBurstLen, paramBurstOpts,
        input  dataValid, dataValue, doneStop,
        output paramsStop, dataStop, doneValid, doneStatusOk
    );
endinterface

// File: rtl/smi_mem_write_burst_arbiter_2x_rr_arbiter2.sv
// Two-way round-robin picker: on a tie the side that did not win last time wins.
module smi_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       lastGrant,
    output logic       grant,
    output logic       grantValid
);
    // Pick a winner among the pending requests
    always_comb begin
        grantValid = |req;
        grant      = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~lastGrant;
            default: grant = 1'b0;
        endcase
    end
endmodule

// File: rtl/smi_mem_write_burst_arbiter_2x.sv
// Shares one write burst controller between two requesters, one burst per grant.
module smi_mem_write_burst_arbiter_2x
    import smi_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic clk,
    input  logic srst,
    smi_mem_write_burst_arbiter_2x_if.slave  r0,
    smi_mem_write_burst_arbiter_2x_if.slave  r1,
    smi_mem_write_burst_arbiter_2x_if.master wr,
    output logic grantActive,
    output logic grantId
);
    arbState_t         state;
    logic              lastGrant;
    logic [LEN_W-1:0]  beatCount;

    logic              arbGrant;
    logic              arbValid;
    logic              inParams;
    logic              inData;
    logic              inDone;
    logic              selParamsValid;
    logic              selDataValid;
    logic              selDoneStop;
    logic [ADDR_W-1:0] selAddr;
    logic [LEN_W-1:0]  selLen;
    logic [OPTS_W-1:0] selOpts;
    logic [DATA_W-1:0] selData;
    logic              paramsXfer;
    logic              dataXfer;
    logic              doneXfer;

    smi_rr_arbiter2 uArb (
        .req        ({r1.paramsValid, r0.paramsValid}),
        .lastGrant  (lastGrant),
        .grant      (arbGrant),
        .grantValid (arbValid)
    );

    assign inParams = (state == Params);
    assign inData   = (state == Data);
    assign inDone   = (state == Done);

    // Grantee selection muxes
    assign selParamsValid = grantId ? r1.paramsValid    : r0.paramsValid;
    assign selAddr        = grantId ? r1.paramBurstAddr : r0.paramBurstAddr;
    assign selLen         = grantId ? r1.paramBurstLen  : r0.paramBurstLen;
    assign selOpts        = grantId ? r1.paramBurstOpts : r0.paramBurstOpts;
    assign selDataValid   = grantId ? r1.dataValid      : r0.dataValid;
    assign selData        = grantId ? r1.dataValue      : r0.dataValue;
    assign selDoneStop    = grantId ? r1.doneStop       : r0.doneStop;

    // Controller-facing channels: only the phase in progress is ever valid
    assign wr.paramsValid    = inParams & selParamsValid;
    assign wr.paramBurstAddr = selAddr;
    assign wr.paramBurstLen  = selLen;
    assign wr.paramBurstOpts = selOpts;
    assign wr.dataValid      = inData & selDataValid;
    assign wr.dataValue      = selData;
    assign wr.doneStop       = inDone ? selDoneStop : 1'b1;

    // Requester-facing backpressure: the non-grantee is always stalled
    assign r0.paramsStop   = (inParams && !grantId) ? wr.paramsStop : 1'b1;
    assign r1.paramsStop   = (inParams &&  grantId) ? wr.paramsStop : 1'b1;
    assign r0.dataStop     = (inData   && !grantId) ? wr.dataStop   : 1'b1;
    assign r1.dataStop     = (inData   &&  grantId) ? wr.dataStop   : 1'b1;
    assign r0.doneValid    = inDone && !grantId && wr.doneValid;
    assign r1.doneValid    = inDone &&  grantId && wr.doneValid;
    assign r0.doneStatusOk = inDone && !grantId && wr.doneValid && wr.doneStatusOk;
    assign r1.doneStatusOk = inDone &&  grantId && wr.doneValid && wr.doneStatusOk;

    assign paramsXfer = wr.paramsValid && !wr.paramsStop;
    assign dataXfer   = wr.dataValid && !wr.dataStop;
    assign doneXfer   = wr.doneValid && !wr.doneStop;

    // Arbitration and per-burst sequencing; beatCount is at least 1 whenever in Data
    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= Idle;
            grantId     <= 1'b0;
            grantActive <= 1'b0;
            lastGrant   <= 1'b1;
            beatCount   <= '0;
        end else begin
            case (state)
                Idle: begin
                    if (arbValid) begin
                        grantId     <= arbGrant;
                        grantActive <= 1'b1;
                        state       <= Params;
                    end
                end
                Params: begin
                    if (paramsXfer) begin
                        beatCount <= selLen;
                        state     <= (selLen == '0) ? Done : Data;
                    end
                end
                Data: begin
                    if (dataXfer) begin
                        beatCount <= beatCount - LEN_W'(1);
                        if (beatCount == LEN_W'(1)) begin
                            state <= Done;
                        end
                    end
                end
                Done: begin
                    if (doneXfer) begin
                        lastGrant   <= grantId;
                        grantActive <= 1'b0;
                        state       <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule

// File: tb/tb_smi_mem_write_burst_arbiter_2x.sv
// Bench for the two-port write burst arbiter: directed table, corner sequences, random bursts.
module tb_smi_mem_write_burst_arbiter_2x;
    import smi_mem_arb_pkg::*;

    localparam logic [9:0] RST_VEC = 10'b0_11111_0000;

    typedef struct {
        logic [1:0] mask;
        int         len;
        logic       st;
        logic       expG;
    } vec_t;

    logic clk = 1'b0;
    logic srst;
    logic grantActive;
    logic grantId;
    int   passCnt = 0;
    int   totalCnt = 0;

    smi_mem_write_burst_arbiter_2x_if r0If ();
    smi_mem_write_burst_arbiter_2x_if r1If ();
    smi_mem_write_burst_arbiter_2x_if wrIf ();

    smi_mem_write_burst_arbiter_2x dut (
        .clk         (clk),
        .srst        (srst),
        .r0          (r0If),
        .r1          (r1If),
        .wr          (wrIf),
        .grantActive (grantActive),
        .grantId     (grantId)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [9:0] outVec();
        return {grantActive, r0If.paramsStop, r0If.dataStop, r1If.paramsStop, r1If.dataStop,
                wrIf.doneStop, wrIf.paramsValid, wrIf.dataValid, r0If.doneValid, r1If.doneValid};
    endfunction

    // Beat k of a burst from requester id carries the id in the upper word
    function automatic logic [63:0] beatVal(input logic id, input int k);
        return {31'd0, id, 32'(k)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete burst from Idle. stopMode: 0 no stalls, 1 dataStop toggles, 2 random stalls.
    // rstAfter >= 0 pulses srst once that many beats have been accepted.
    task automatic runBurst(input string nm, input logic [1:0] mask, input int len,
                            input logic [63:0] addr, input logic st, input logic expG,
                            input int stopMode, input int doneHold, input int rstAfter);
        logic [63:0] expA;
        int          wrBeats;
        int          rqBeats;
        int          extra;
        bit          got;
        logic        gStop;
        logic        lStop;
        expA = expG ? addr + 64'h10 : addr;
        r0If.paramsValid    = mask[0];
        r0If.paramBurstAddr = addr;
        r0If.paramBurstLen  = 32'(len);
        r0If.paramBurstOpts = 8'h30;
        r1If.paramsValid    = mask[1];
        r1If.paramBurstAddr = addr + 64'h10;
        r1If.paramBurstLen  = 32'(len);
        r1If.paramBurstOpts = 8'h31;
        wrIf.paramsStop   = 1'b0;
        wrIf.dataStop     = 1'b0;
        wrIf.doneValid    = 1'b0;
        wrIf.doneStatusOk = 1'b0;
        r0If.doneStop     = 1'b0;
        r1If.doneStop     = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (stopMode == 2) wrIf.paramsStop = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (wrIf.paramsValid && !wrIf.paramsStop) begin
                got = 1'b1;
                chk({nm, " grantId"}, 64'(grantId), 64'(expG));
                chk({nm, " addr"}, wrIf.paramBurstAddr, expA);
                chk({nm, " len/opts"}, {24'd0, wrIf.paramBurstLen, wrIf.paramBurstOpts},
                    {24'd0, 32'(len), (expG ? 8'h31 : 8'h30)});
                chk({nm, " loser paramsStop"}, 64'(expG ? r0If.paramsStop : r1If.paramsStop), 64'd1);
            end
            step();
        end
        chk({nm, " params handshake seen"}, 64'(got), 64'd1);
        r0If.paramsValid = 1'b0;
        r1If.paramsValid = 1'b0;
        wrIf.paramsStop  = 1'b0;

        wrBeats = 0;
        rqBeats = 0;
        extra   = 0;
        for (int c = 0; c < 8 * len + 40 && extra < 3; c++) begin
            if (rstAfter >= 0 && rqBeats == rstAfter) break;
            r0If.dataValid = 1'b1;
            r1If.dataValid = 1'b1;
            r0If.dataValue = expG ? (64'hDEAD_BEEF_0000_0000 | 64'(c)) : beatVal(1'b0, rqBeats);
            r1If.dataValue = expG ? beatVal(1'b1, rqBeats) : (64'hDEAD_BEEF_0000_0000 | 64'(c));
            wrIf.dataStop  = (stopMode == 1) ? 1'(c % 2) :
                             (stopMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            gStop = expG ? r1If.dataStop : r0If.dataStop;
            lStop = expG ? r0If.dataStop : r1If.dataStop;
            if (wrIf.dataValid && !wrIf.dataStop) begin
                chk($sformatf("%s beat%0d", nm, wrBeats), wrIf.dataValue, beatVal(expG, wrBeats));
                chk($sformatf("%s loser dataStop%0d", nm, wrBeats), 64'(lStop), 64'd1);
                wrBeats++;
            end
            if (!gStop) rqBeats++;
            if (rqBeats >= len) extra++;
            step();
        end
        r0If.dataValid = 1'b0;
        r1If.dataValid = 1'b0;
        wrIf.dataStop  = 1'b0;

        if (rstAfter >= 0) begin
            chk({nm, " beats before reset"}, 64'(wrBeats), 64'(rstAfter));
            srst = 1'b1;
            step();
            srst = 1'b0;
            @(negedge clk);
            chk({nm, " outputs after reset"}, 64'(outVec()), 64'(RST_VEC));
            step();
        end else begin
            chk({nm, " beat count"}, 64'(wrBeats), 64'(len));
            wrIf.doneValid    = 1'b1;
            wrIf.doneStatusOk = st;
            for (int h = 0; h < doneHold; h++) begin
                if (expG) r1If.doneStop = 1'b1;
                else      r0If.doneStop = 1'b1;
                @(negedge clk);
                chk($sformatf("%s done hold%0d", nm, h),
                    {61'd0, wrIf.doneStop, grantActive, (expG ? r1If.doneValid : r0If.doneValid)}, 64'd7);
                step();
            end
            r0If.doneStop = 1'b0;
            r1If.doneStop = 1'b0;
            @(negedge clk);
            chk({nm, " done routing"},
                {59'd0, r0If.doneValid, r0If.doneStatusOk, r1If.doneValid, r1If.doneStatusOk, wrIf.doneStop},
                expG ? {59'd0, 2'b00, 1'b1, st, 1'b0} : {59'd0, 1'b1, st, 2'b00, 1'b0});
            step();
            wrIf.doneValid    = 1'b0;
            wrIf.doneStatusOk = 1'b0;
            @(negedge clk);
            chk({nm, " back to idle"}, 64'(grantActive), 64'd0);
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the test finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [8];
        logic        mLast;
        logic [1:0]  m;
        int          l;
        logic        s;
        logic        eg;

        tbl[0] = '{2'b11, 2, 1'b1, 1'b0};
        tbl[1] = '{2'b11, 3, 1'b1, 1'b1};
        tbl[2] = '{2'b11, 1, 1'b0, 1'b0};
        tbl[3] = '{2'b10, 0, 1'b1, 1'b1};
        tbl[4] = '{2'b11, 0, 1'b0, 1'b0};
        tbl[5] = '{2'b01, 1, 1'b1, 1'b0};
        tbl[6] = '{2'b11, 2, 1'b1, 1'b1};
        tbl[7] = '{2'b01, 0, 1'b1, 1'b0};

        srst = 1'b1;
        r0If.paramsValid = 1'b0; r0If.paramBurstAddr = '0; r0If.paramBurstLen = '0; r0If.paramBurstOpts = '0;
        r0If.dataValid = 1'b0;   r0If.dataValue = '0;     r0If.doneStop = 1'b0;
        r1If.paramsValid = 1'b0; r1If.paramBurstAddr = '0; r1If.paramBurstLen = '0; r1If.paramBurstOpts = '0;
        r1If.dataValid = 1'b0;   r1If.dataValue = '0;     r1If.doneStop = 1'b0;
        wrIf.paramsStop = 1'b0;  wrIf.dataStop = 1'b0;    wrIf.doneValid = 1'b0; wrIf.doneStatusOk = 1'b0;

        // Reset state
        step();
        step();
        @(negedge clk);
        chk("reset outputs", 64'(outVec()), 64'(RST_VEC));
        chk("reset grantId", 64'(grantId), 64'd0);
        step();
        srst = 1'b0;

        // Single requester, four in-order beats
        runBurst("r0only", 2'b01, 4, 64'h1000, 1'b1, 1'b0, 0, 0, -1);

        // Arbitration table from a fresh reset (r0 wins the first tie)
        srst = 1'b1;
        step();
        srst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            runBurst($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].len, 64'h2000 + 64'(i) * 64'h100,
                     tbl[i].st, tbl[i].expG, 0, 0, -1);
        end

        // Len 8 with dataStop toggling every other cycle
        runBurst("toggle8", 2'b10, 8, 64'h3000, 1'b1, 1'b1, 1, 0, -1);

        // Controller completion outside Done is not forwarded
        wrIf.doneValid    = 1'b1;
        wrIf.doneStatusOk = 1'b1;
        @(negedge clk);
        chk("stray done", {59'd0, r0If.doneValid, r0If.doneStatusOk, r1If.doneValid, r1If.doneStatusOk,
                           wrIf.doneStop}, 64'd1);
        step();
        wrIf.doneValid    = 1'b0;
        wrIf.doneStatusOk = 1'b0;

        // Requester holds off completion for five cycles
        runBurst("doneHold", 2'b10, 1, 64'h4000, 1'b1, 1'b1, 0, 5, -1);

        // Reset in the middle of a data phase, then a fresh grant
        runBurst("midRst", 2'b01, 6, 64'h5000, 1'b1, 1'b0, 0, 0, 2);
        runBurst("afterRst", 2'b10, 0, 64'h6000, 1'b1, 1'b1, 0, 0, -1);

        // Random bursts against a round-robin model
        mLast = 1'b1;
        for (int b = 0; b < 40; b++) begin
            m  = 2'($urandom_range(1, 3));
            l  = $urandom_range(0, 5);
            s  = 1'($urandom_range(0, 1));
            eg = (m == 2'b11) ? ~mLast : m[1];
            runBurst($sformatf("rnd%0d", b), m, l, {$urandom, $urandom}, s, eg, 2,
                     $urandom_range(0, 3), -1);
            mLast = eg;
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
